// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, one-word-per-line data cache between a core's SRAM-style
// data port and a single-outstanding backing-memory interface.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   data_sram_*         core request (en, wen, addr, wdata) and load data (rdata)
//   stall_from_cache    core must hold its request
//   mem_req/mem_wr      backing-memory request and direction
//   mem_addr/wdata/wstrb  request payload, stable while mem_req=1
//   mem_rdata/mem_ready   memory read data and one-cycle completion pulse
//
// Reads hit in the same cycle. Misses and uncached reads go to memory and fill the line when
// the address is cached. Stores are write-through, no-allocate: a store that hits merges its
// bytes into the line when memory completes it.
module dcache_responder #(
    parameter int unsigned LINES    = 64,
    parameter logic [15:0] UNC_BASE = 16'h1faf
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stall_from_cache,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int unsigned IW = $clog2(LINES);
    localparam int unsigned TW = 30 - IW;

    typedef enum logic [1:0] {StIdle, StMemRd, StMemWr, StResp} state_e;

    state_e            state_q;
    logic [LINES-1:0]  valid_q;
    logic [TW-1:0]     tag_q  [LINES];
    logic [31:0]       data_q [LINES];
    logic [29:0]       addr_q;       // word address of the in-flight request
    logic [3:0]        wen_q;
    logic [31:0]       wdata_q;
    logic [31:0]       resp_q;
    logic              mem_req_q;
    logic              mem_wr_q;

    // Byte offset of a word-aligned address carries no information.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^data_sram_addr[1:0];

    // Lookup for the incoming core request.
    logic [IW-1:0] in_idx;
    logic [TW-1:0] in_tag;
    logic          in_unc;
    logic          in_hit;

    assign in_idx = data_sram_addr[IW+1:2];
    assign in_tag = data_sram_addr[31:IW+2];
    assign in_unc = (data_sram_addr[31:16] == UNC_BASE);
    assign in_hit = !in_unc && valid_q[in_idx] && (tag_q[in_idx] == in_tag);

    // Lookup for the latched request, used when memory completes.
    logic [IW-1:0] q_idx;
    logic [TW-1:0] q_tag;
    logic          q_unc;
    logic          q_hit;

    assign q_idx = addr_q[IW-1:0];
    assign q_tag = addr_q[29:IW];
    assign q_unc = (addr_q[29:14] == UNC_BASE);
    assign q_hit = !q_unc && valid_q[q_idx] && (tag_q[q_idx] == q_tag);

    logic        rd_done;
    logic        wr_done;
    logic        line_we;
    logic [31:0] line_wdata;

    assign rd_done = (state_q == StMemRd) && mem_ready;
    assign wr_done = (state_q == StMemWr) && mem_ready;

    // Fill on a cached read completion; merge only on a store hit (no-allocate).
    assign line_we = (rd_done && !q_unc) || (wr_done && q_hit);

    always_comb begin
        line_wdata = data_q[q_idx];
        if (state_q == StMemRd) begin
            line_wdata = mem_rdata;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (wen_q[b]) begin
                    line_wdata[8*b +: 8] = wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[q_idx]  <= q_tag;
            data_q[q_idx] <= line_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            valid_q   <= '0;
            addr_q    <= '0;
            wen_q     <= '0;
            wdata_q   <= '0;
            resp_q    <= '0;
            mem_req_q <= 1'b0;
            mem_wr_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (data_sram_en) begin
                        if (data_sram_wen != 4'b0000) begin
                            addr_q    <= data_sram_addr[31:2];
                            wen_q     <= data_sram_wen;
                            wdata_q   <= data_sram_wdata;
                            mem_req_q <= 1'b1;
                            mem_wr_q  <= 1'b1;
                            state_q   <= StMemWr;
                        end else if (!in_hit) begin
                            addr_q    <= data_sram_addr[31:2];
                            wen_q     <= data_sram_wen;
                            wdata_q   <= data_sram_wdata;
                            mem_req_q <= 1'b1;
                            mem_wr_q  <= 1'b0;
                            state_q   <= StMemRd;
                        end
                    end
                end
                StMemRd: begin
                    if (mem_ready) begin
                        resp_q    <= mem_rdata;
                        mem_req_q <= 1'b0;
                        state_q   <= StResp;
                        if (!q_unc) begin
                            valid_q[q_idx] <= 1'b1;
                        end
                    end
                end
                StMemWr: begin
                    if (mem_ready) begin
                        // Stores return zero load data in the response cycle.
                        resp_q    <= '0;
                        mem_req_q <= 1'b0;
                        mem_wr_q  <= 1'b0;
                        state_q   <= StResp;
                    end
                end
                StResp: begin
                    // The request still presented here is the one just completed.
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Stall is combinational in IDLE so a miss is held in the very cycle it is seen.
    always_comb begin
        stall_from_cache = 1'b0;
        data_sram_rdata  = '0;
        unique case (state_q)
            StIdle: begin
                if (rst && data_sram_en) begin
                    if (data_sram_wen == 4'b0000 && in_hit) begin
                        data_sram_rdata = data_q[in_idx];
                    end else begin
                        stall_from_cache = 1'b1;
                    end
                end
            end
            StMemRd, StMemWr: stall_from_cache = 1'b1;
            StResp:           data_sram_rdata  = resp_q;
            default: ;
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = {addr_q, 2'b00};
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wen_q;

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: cold miss, hits, write-through merge, write miss
// without allocation, uncached reads, index eviction, spurious mem_ready and mid-transaction reset.
module tb_dcache_responder;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int total = 0;
    int bad   = 0;

    dcache_responder #(
        .LINES    (64),
        .UNC_BASE (16'h1faf)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .data_sram_en     (en),
        .data_sram_wen    (wen),
        .data_sram_addr   (addr),
        .data_sram_wdata  (wdata),
        .data_sram_rdata  (rdata),
        .stall_from_cache (stall),
        .mem_req          (mem_req),
        .mem_wr           (mem_wr),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_wstrb        (mem_wstrb),
        .mem_rdata        (mem_rdata),
        .mem_ready        (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One core transaction. Memory answers after 'lat' request cycles with 'mrd'.
    // Returns the number of stalled cycles and the load data seen once stall drops.
    task automatic xact(input logic [31:0] a, input logic [3:0] w, input logic [31:0] wd,
                        input int lat, input logic [31:0] mrd,
                        output int ns, output logic [31:0] r);
        int wc;
        bit done;
        logic [31:0] exp_addr;
        ns       = 0;
        wc       = 0;
        done     = 1'b0;
        r        = '0;
        exp_addr = {a[31:2], 2'b00};
        @(negedge clk);
        en    = 1'b1;
        wen   = w;
        addr  = a;
        wdata = wd;
        for (int c = 0; c < 30 && !done; c++) begin
            if (c != 0) begin
                @(negedge clk);
                mem_ready = 1'b0;
            end
            #1;
            if (!stall) begin
                r    = rdata;
                done = 1'b1;
            end else begin
                ns++;
                if (mem_req) begin
                    chk("mem_wr", {31'b0, mem_wr}, {31'b0, w != 4'b0000});
                    chk("mem_addr", mem_addr, exp_addr);
                    chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, w});
                    chk("mem_wdata", mem_wdata, wd);
                    if (wc == lat) begin
                        mem_ready = 1'b1;
                        mem_rdata = mrd;
                    end
                    wc++;
                end
            end
        end
        if (!done) chk("timeout", 32'd0, 32'd1);
        en  = 1'b0;
        wen = 4'b0000;
    endtask

    task automatic rd_case(input string tag, input logic [31:0] a, input int lat,
                           input logic [31:0] mrd, input int exp_ns, input logic [31:0] exp_r);
        int ns;
        logic [31:0] r;
        xact(a, 4'b0000, 32'h0, lat, mrd, ns, r);
        chk({tag, "_stalls"}, ns, exp_ns);
        chk({tag, "_rdata"}, r, exp_r);
    endtask

    task automatic wr_case(input string tag, input logic [31:0] a, input logic [3:0] w,
                           input logic [31:0] wd, input int lat, input int exp_ns);
        int ns;
        logic [31:0] r;
        xact(a, w, wd, lat, 32'h0, ns, r);
        chk({tag, "_stalls"}, ns, exp_ns);
        chk({tag, "_rdata"}, r, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        en        = 1'b1;
        wen       = 4'b0000;
        addr      = 32'h0000_0100;
        wdata     = 32'h0;
        mem_rdata = 32'h0;
        mem_ready = 1'b0;

        // Reset state, with a request already pending on the core side.
        #3;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("idle_stall", {31'b0, stall}, 32'd0);
        chk("idle_rdata", rdata, 32'h0);
        chk("idle_mem_req", {31'b0, mem_req}, 32'd0);

        // Cold miss, then hit.
        rd_case("cold", 32'h0000_0100, 3, 32'hDEAD_BEEF, 5, 32'hDEAD_BEEF);
        rd_case("hit", 32'h0000_0100, 0, 32'h0, 0, 32'hDEAD_BEEF);

        // Write-through merges into the hit line.
        wr_case("st_b0", 32'h0000_0100, 4'b0001, 32'h0000_00AA, 1, 3);
        rd_case("raw_b0", 32'h0000_0100, 0, 32'h0, 0, 32'hDEAD_BEAA);
        wr_case("st_b32", 32'h0000_0100, 4'b1100, 32'h1234_5678, 0, 2);
        rd_case("raw_b32", 32'h0000_0100, 0, 32'h0, 0, 32'h1234_BEAA);

        // Store miss does not allocate.
        wr_case("st_miss", 32'h0000_0204, 4'b1111, 32'h9999_9999, 0, 2);
        rd_case("rd_after_stmiss", 32'h0000_0204, 2, 32'h1111_2222, 4, 32'h1111_2222);

        // Uncached reads always go to memory and leave index 0 alone.
        rd_case("unc1", 32'h1FAF_F000, 3, 32'hCAFE_F00D, 5, 32'hCAFE_F00D);
        rd_case("unc2", 32'h1FAF_F000, 3, 32'h0BAD_CAFE, 5, 32'h0BAD_CAFE);
        rd_case("after_unc", 32'h0000_0100, 0, 32'h0, 0, 32'h1234_BEAA);

        // Index conflict eviction.
        rd_case("evict_a", 32'h0000_0000, 1, 32'hA0A0_A0A0, 3, 32'hA0A0_A0A0);
        rd_case("evict_b", 32'h0000_0100, 1, 32'hB0B0_B0B0, 3, 32'hB0B0_B0B0);
        rd_case("evict_a2", 32'h0000_0000, 1, 32'hC0C0_C0C0, 3, 32'hC0C0_C0C0);

        // Spurious mem_ready in IDLE.
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = 32'h5555_5555;
        #1;
        chk("spur_stall", {31'b0, stall}, 32'd0);
        chk("spur_rdata", rdata, 32'h0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("spur_mem_req", {31'b0, mem_req}, 32'd0);
        rd_case("spur_hit", 32'h0000_0000, 0, 32'h0, 0, 32'hC0C0_C0C0);

        // Reset while a read is outstanding.
        @(negedge clk);
        en   = 1'b1;
        wen  = 4'b0000;
        addr = 32'h0000_0300;
        @(negedge clk);
        #1;
        chk("mid_mem_req", {31'b0, mem_req}, 32'd1);
        chk("mid_stall", {31'b0, stall}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("mid_rst_stall", {31'b0, stall}, 32'd0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rd_case("post_rst", 32'h0000_0300, 1, 32'h3333_3333, 3, 32'h3333_3333);
        rd_case("post_rst_inv", 32'h0000_0000, 1, 32'h4444_4444, 3, 32'h4444_4444);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
